cache_fill_ctrl: RTL and testbench
==================================

// Module: cache_fill_ctrl
// PURPOSE
//  Read-only direct-mapped cache controller that owns one dpram_32x32 data store (32 words).
//  - Serves CPU word reads.
//  - Detects misses against an internal tag/valid array.
//  - Sequences burst line fills from the memory interface into the dpram.
//  - Replays the missed read once the fill completes.
//  - Sits between the fetch/load unit and the memory bus.
// PARAMETERS
//  LINES  4   cache lines; LINES*WORDS must equal 32 (dpram depth)
//  WORDS  8   32-bit words per line = burst length per fill
//  ADDRW  32  CPU/memory byte-address width
// PORTS
//  clk         in   1      single clock; all state on posedge
//  reset       in   1      asynchronous, active-high
//  cpu_req     in   1      read request; sampled only while cpu_busy=0
//  cpu_addr    in   ADDRW  byte address; [1:0] ignored
//  cpu_busy    out  1      request not accepted this cycle
//  cpu_valid   out  1      one-cycle pulse; cpu_rdata valid
//  cpu_rdata   out  32     read data
//  flush       in   1      pulse; invalidate all lines
//  mem_req     out  1      line-fill request; held until mem_ack
//  mem_addr    out  ADDRW  line-aligned fill address, stable while mem_req=1
//  mem_ack     in   1      fill accepted
//  mem_rvalid  in   1      fill data beat
//  mem_rdata   in   32     fill data
// BEHAVIOUR
//  Address fields (defaults):
//   - word = addr[4:2]; line = addr[6:5]; tag = addr[ADDRW-1:7].
//   - dpram address = {line,word}.
//  Reset values:
//   - state IDLE; all valid bits 0.
//   - cpu_busy=0, cpu_valid=0, cpu_rdata=0, mem_req=0, mem_addr=0.
//   - dpram contents are not cleared.
//  States:
//   - IDLE: cpu_busy=0; dpram raddr driven combinationally from cpu_addr.
//     cpu_req=1 -> latch addr -> LOOKUP.
//   - LOOKUP: dpram dataout holds the word; cpu_busy=1.
//     Hit (valid[line] & tag match) -> cpu_valid=1, cpu_rdata=dataout -> IDLE.
//     Miss -> clear valid[line] -> FILL_REQ.
//   - FILL_REQ: mem_req=1, mem_addr={tag,line,5'b0}.
//     On mem_ack -> mem_req=0, beat cnt=0 -> FILL_DATA.
//   - FILL_DATA: each mem_rvalid writes mem_rdata to {line,cnt} (we=1), cnt++.
//     After beat WORDS-1: tag[line]=tag, valid[line]=1 -> REPLAY.
//   - REPLAY: raddr={line,word} -> LOOKUP. The last write has already landed, so the read returns new data.
//  Latency:
//   - Hit: cpu_valid one cycle after cpu_req is sampled.
//   - Miss: cpu_valid 2 cycles after the last beat.
//   - Throughput: at most one request per 2 cycles.
//  Boundary and corner cases:
//   - cpu_req while cpu_busy=1: ignored; requester must hold the request.
//   - mem_rvalid outside FILL_DATA: ignored.
//   - mem_ack and mem_rvalid in the same cycle: beat not counted; memory sends beats after ack.
//   - flush: clears all valid bits in any state.
//   - flush in the same cycle as the final beat: flush wins; the line stays invalid.
//     The replay then misses and refetches.
//   - flush during FILL_DATA: the in-flight fill still marks its line valid at completion.
//   - reset mid-fill: immediate abort; mem_req drops; remaining beats ignored.
//   - cnt width: log2(WORDS); wraps only at fill end.
// STRUCTURE
//  Shared package cache_pkg:
//   - FSM state enum.
//   - Field widths/offsets (WORD_BITS, LINE_BITS, TAG_BITS).
//   - LINES/WORDS defaults.
//  Sub-module: one dpram_32x32 instance as the data store.
//  Tag/valid arrays are flops inside this block.
// TESTING
//  1 reset; read 0x100 -> miss, mem_addr=0x100.
//    Feed beats 0xA0..0xA7 -> cpu_rdata=0xA0.
//    Then read 0x11C -> hit, 0xA7, cpu_valid exactly 1 cycle after req.
//  2 after test 1, read 0x180 (same line, new tag) -> mem_req with mem_addr=0x180.
//    Refill 0xB0..0xB7 -> 0xB0. Then read 0x100 -> miss again.
//  3 line 0 valid; pulse flush; read 0x104 -> miss, mem_addr=0x100.
//  4 miss with mem_ack delayed 5 cycles -> mem_req high and mem_addr constant all 5 cycles.
//    Stray mem_rvalid before ack causes no dpram write.
//  5 assert reset after 3 of 8 beats -> mem_req=0, cpu_busy=0.
//    Next read 0x100 misses and refetches.
//  6 flush in the same cycle as beat 7 -> replay misses.
//    Second mem_req issued for the same line.

Source files
------------

// File: rtl/cache_fill_ctrl_pkg.sv
// Shared types and field geometry for the direct-mapped read cache.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cache_pkg;

  // Default geometry: 4 lines x 8 words fills the 32-entry data store.
  localparam int LINES_DEF = 4;
  localparam int WORDS_DEF = 8;
  localparam int ADDRW_DEF = 32;

  // Byte address split: {tag, line, word, byte}.
  localparam int BYTE_BITS = 2;
  localparam int WORD_BITS = $clog2(WORDS_DEF);
  localparam int LINE_BITS = $clog2(LINES_DEF);
  localparam int TAG_BITS  = ADDRW_DEF - LINE_BITS - WORD_BITS - BYTE_BITS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_FILL_REQ,
    ST_FILL_DATA,
    ST_REPLAY
  } state_t;

endpackage

// File: rtl/cache_fill_ctrl_if.sv
// CPU read port and memory fill port of the cache controller in one bundle.
// Latency: n/a (wires only).
// Backpressure: cpu side via cpu_busy; memory side via mem_req/mem_ack hold.
interface cache_fill_ctrl_if #(
  parameter int ADDRW = 32
);
  logic             cpu_req;
  logic [ADDRW-1:0] cpu_addr;
  logic             cpu_busy;
  logic             cpu_valid;
  logic [31:0]      cpu_rdata;
  logic             flush;
  logic             mem_req;
  logic [ADDRW-1:0] mem_addr;
  logic             mem_ack;
  logic             mem_rvalid;
  logic [31:0]      mem_rdata;

  // Environment side: the requesting CPU plus the memory responder.
  modport master (
    output cpu_req, cpu_addr, flush, mem_ack, mem_rvalid, mem_rdata,
    input  cpu_busy, cpu_valid, cpu_rdata, mem_req, mem_addr
  );

  // Controller side.
  modport slave (
    input  cpu_req, cpu_addr, flush, mem_ack, mem_rvalid, mem_rdata,
    output cpu_busy, cpu_valid, cpu_rdata, mem_req, mem_addr
  );
endinterface

// File: rtl/cache_fill_ctrl_dpram.sv
// 32x32 dual-port RAM: one write port, one registered read port.
// Latency: read data appears one cycle after raddr; writes land at the clock edge.
// Backpressure: none, accepts a read and a write every cycle.
module dpram_32x32 (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr,
  output logic [31:0] dataout
);
  logic [31:0] mem [32];

  // Contents are never cleared; the read port is a plain registered read.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    dataout <= mem[raddr];
  end
endmodule

// File: rtl/cache_fill_ctrl.sv
// Direct-mapped read-only cache: serves CPU reads, fills missed lines in bursts, replays the read.
// Latency: hit returns one cycle after the request; miss returns two cycles after the last beat.
// Backpressure: cpu_busy holds off new requests outside IDLE; mem_req held until mem_ack.
module cache_fill_ctrl
  import cache_pkg::*;
#(
  parameter int LINES = LINES_DEF,
  parameter int WORDS = WORDS_DEF,
  parameter int ADDRW = ADDRW_DEF
) (
  input logic               clk,
  input logic               reset,
  cache_fill_ctrl_if.slave  bus
);
  localparam int RAM_AW = LINE_BITS + WORD_BITS;

  state_t                state, state_n;
  logic [TAG_BITS-1:0]   tag_q;
  logic [LINE_BITS-1:0]  line_q;
  logic [WORD_BITS-1:0]  word_q;
  logic [WORD_BITS-1:0]  cnt;
  logic [LINES-1:0]      valid;
  logic [TAG_BITS-1:0]   tags [LINES];

  logic                  we;
  logic [RAM_AW-1:0]     raddr, waddr;
  logic [31:0]           dataout;
  logic                  hit, last_beat, unused_byte_bits;

  logic                  cpu_busy_c, cpu_valid_c, mem_req_c;
  logic [31:0]           cpu_rdata_c;
  logic [ADDRW-1:0]      mem_addr_c;

  assign hit       = valid[line_q] && (tags[line_q] == tag_q);
  assign last_beat = bus.mem_rvalid && (cnt == WORD_BITS'(WORDS - 1));
  // Byte offset within a word plays no part in a word read.
  assign unused_byte_bits = ^bus.cpu_addr[BYTE_BITS-1:0];

  dpram_32x32 u_ram (
    .clk     (clk),
    .we      (we),
    .waddr   (waddr),
    .wdata   (bus.mem_rdata),
    .raddr   (raddr),
    .dataout (dataout)
  );

  // State, captured request fields, beat counter and valid bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      valid  <= '0;
      cnt    <= '0;
      tag_q  <= '0;
      line_q <= '0;
      word_q <= '0;
    end else begin
      state <= state_n;
      if (state == ST_IDLE && bus.cpu_req) begin
        word_q <= bus.cpu_addr[BYTE_BITS +: WORD_BITS];
        line_q <= bus.cpu_addr[BYTE_BITS+WORD_BITS +: LINE_BITS];
        tag_q  <= bus.cpu_addr[ADDRW-1 -: TAG_BITS];
      end
      if (state == ST_LOOKUP && !hit) valid[line_q] <= 1'b0;
      if (state == ST_FILL_REQ && bus.mem_ack) cnt <= '0;
      if (state == ST_FILL_DATA && bus.mem_rvalid) begin
        cnt <= cnt + 1'b1;
        if (last_beat) valid[line_q] <= 1'b1;
      end
      // Flush is last so it overrides a fill completing in the same cycle.
      if (bus.flush) valid <= '0;
    end
  end

  // Tag store needs no reset: a tag is only consulted behind its valid bit.
  always_ff @(posedge clk) begin
    if (state == ST_FILL_DATA && last_beat) tags[line_q] <= tag_q;
  end

  // Next state plus all handshake outputs and data-store controls.
  always_comb begin
    state_n     = state;
    cpu_busy_c  = 1'b1;
    cpu_valid_c = 1'b0;
    cpu_rdata_c = '0;
    mem_req_c   = 1'b0;
    mem_addr_c  = '0;
    we          = 1'b0;
    waddr       = {line_q, cnt};
    raddr       = {line_q, word_q};
    case (state)
      ST_IDLE: begin
        cpu_busy_c = 1'b0;
        raddr = {bus.cpu_addr[BYTE_BITS+WORD_BITS +: LINE_BITS],
                 bus.cpu_addr[BYTE_BITS +: WORD_BITS]};
        if (bus.cpu_req) state_n = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        if (hit) begin
          cpu_valid_c = 1'b1;
          cpu_rdata_c = dataout;
          state_n     = ST_IDLE;
        end else begin
          state_n = ST_FILL_REQ;
        end
      end
      ST_FILL_REQ: begin
        mem_req_c  = 1'b1;
        mem_addr_c = {tag_q, line_q, {(WORD_BITS+BYTE_BITS){1'b0}}};
        if (bus.mem_ack) state_n = ST_FILL_DATA;
      end
      ST_FILL_DATA: begin
        if (bus.mem_rvalid) begin
          we = 1'b1;
          if (last_beat) state_n = ST_REPLAY;
        end
      end
      ST_REPLAY: state_n = ST_LOOKUP;
      default:   state_n = ST_IDLE;
    endcase
  end

  assign bus.cpu_busy  = cpu_busy_c;
  assign bus.cpu_valid = cpu_valid_c;
  assign bus.cpu_rdata = cpu_rdata_c;
  assign bus.mem_req   = mem_req_c;
  assign bus.mem_addr  = mem_addr_c;
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl: hits, misses, refills, flush, delayed ack, reset mid-fill.
// Latency: n/a.
// Backpressure: memory responder acks and streams beats under bench control.
module tb_cache_fill_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  cache_fill_ctrl_if #(.ADDRW(32)) bus ();

  cache_fill_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle; returns at the negedge of the LOOKUP cycle.
  task automatic start_read(input logic [31:0] a);
    @(negedge clk);
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = a;
    @(negedge clk);
    bus.cpu_req  = 1'b0;
  endtask

  task automatic expect_hit(input string t, input logic [31:0] data);
    check({t, "_hit_valid"}, 32'(bus.cpu_valid), 32'd1);
    check({t, "_hit_rdata"}, bus.cpu_rdata, data);
  endtask

  // From LOOKUP: no response, then FILL_REQ with the given line address.
  task automatic expect_miss(input string t, input logic [31:0] maddr);
    check({t, "_miss_valid"}, 32'(bus.cpu_valid), 32'd0);
    check({t, "_miss_busy"}, 32'(bus.cpu_busy), 32'd1);
    @(negedge clk);
    check({t, "_mem_req"}, 32'(bus.mem_req), 32'd1);
    check({t, "_mem_addr"}, bus.mem_addr, maddr);
  endtask

  // Called in a FILL_REQ cycle: ack, stream 8 beats, return in the REPLAY cycle.
  task automatic fill(input string t, input logic [31:0] base, input bit beat_on_ack,
                      input bit flush_last);
    bus.mem_ack = 1'b1;
    if (beat_on_ack) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'hEE;
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.mem_ack = 1'b0;
      if (i == 0) check({t, "_req_drop"}, 32'(bus.mem_req), 32'd0);
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = base + 32'(i);
      bus.flush      = flush_last && (i == 7);
    end
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    bus.flush      = 1'b0;
    check({t, "_replay_quiet"}, 32'(bus.cpu_valid), 32'd0);
  endtask

  task automatic expect_replay_hit(input string t, input logic [31:0] data);
    @(negedge clk);
    expect_hit(t, data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cpu_req = 1'b0; bus.cpu_addr = '0; bus.flush = 1'b0;
    bus.mem_ack = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;

    // Reset state
    @(negedge clk);
    check("rst_busy", 32'(bus.cpu_busy), 32'd0);
    check("rst_valid", 32'(bus.cpu_valid), 32'd0);
    check("rst_rdata", bus.cpu_rdata, 32'd0);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // 1: cold miss, fill, replay, then hit on last word
    start_read(32'h100);
    expect_miss("t1", 32'h100);
    fill("t1", 32'hA0, 1'b0, 1'b0);
    expect_replay_hit("t1_replay", 32'hA0);
    start_read(32'h11C);
    expect_hit("t1_hit", 32'hA7);

    // 2: same line, new tag evicts; old tag then misses
    start_read(32'h180);
    expect_miss("t2", 32'h180);
    fill("t2", 32'hB0, 1'b0, 1'b0);
    expect_replay_hit("t2_replay", 32'hB0);
    start_read(32'h100);
    expect_miss("t2_old", 32'h100);
    fill("t2_old", 32'hA0, 1'b0, 1'b0);
    expect_replay_hit("t2_old_replay", 32'hA0);

    // 3: line 0 valid, flush, same address misses
    start_read(32'h104);
    expect_hit("t3_pre", 32'hA1);
    @(negedge clk); bus.flush = 1'b1;
    @(negedge clk); bus.flush = 1'b0;
    start_read(32'h104);
    expect_miss("t3", 32'h100);
    fill("t3", 32'hC0, 1'b0, 1'b0);
    expect_replay_hit("t3_replay", 32'hC1);

    // 4: ack delayed 5 cycles with a stray beat, ack coincides with a beat
    start_read(32'h220);
    expect_miss("t4", 32'h220);
    for (int k = 1; k < 5; k++) begin
      bus.mem_rvalid = (k == 2);
      bus.mem_rdata  = 32'hDEAD;
      @(negedge clk);
      check("t4_hold_req", 32'(bus.mem_req), 32'd1);
      check("t4_hold_addr", bus.mem_addr, 32'h220);
    end
    bus.mem_rvalid = 1'b0;
    fill("t4", 32'hD0, 1'b1, 1'b0);
    expect_replay_hit("t4_replay", 32'hD0);
    start_read(32'h23C);
    expect_hit("t4_w7", 32'hD7);

    // 5: reset after 3 of 8 beats
    start_read(32'h260);
    expect_miss("t5", 32'h260);
    bus.mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.mem_ack    = 1'b0;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h70 + 32'(i);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t5_rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("t5_rst_busy", 32'(bus.cpu_busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.mem_rvalid = 1'b0;
    start_read(32'h100);
    expect_miss("t5_refetch", 32'h100);
    fill("t5_refetch", 32'hE0, 1'b0, 1'b0);
    expect_replay_hit("t5_replay", 32'hE0);

    // 6: flush on the final beat, replay misses and refetches
    start_read(32'h140);
    expect_miss("t6", 32'h140);
    fill("t6", 32'hF0, 1'b0, 1'b1);
    @(negedge clk);
    expect_miss("t6_replay", 32'h140);
    fill("t6_again", 32'h50, 1'b0, 1'b0);
    expect_replay_hit("t6_replay2", 32'h50);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
